// File: rtl/regfile_dump_if.sv
// -----------------------------------------------------------------------------
// regfile_dump_if
// Bundles the signals between the register-file dump engine and its harness.
//
// Signals:
//   start      harness -> engine  request a dump (sampled only while idle)
//   abort      harness -> engine  synchronous cancel of a dump in progress
//   ra         engine  -> regfile read-port address
//   rd         regfile -> engine  combinational read data for ra
//   out_valid  engine  -> consumer  out_data/out_addr hold a valid word
//   out_ready  consumer -> engine  consumer accepts the word
//   out_data   engine  -> consumer  captured register value
//   out_addr   engine  -> consumer  register index of out_data
//   busy       engine  -> harness  high whenever the engine is not idle
//   done       engine  -> harness  one-cycle pulse after the last word
//   dbg_state  engine  -> harness  current FSM state encoding
//
// Handshake: a word transfers on a rising clk edge where out_valid and
// out_ready are both high. Once out_valid rises, out_valid/out_data/out_addr
// hold steady until that transfer (or an abort/reset). out_ready may be
// driven independently of out_valid.
//
// Modports: master = harness/consumer side, slave = dump engine.
// -----------------------------------------------------------------------------
interface regfile_dump_if;
   logic        start;
   logic        abort;
   logic [4:0]  ra;
   logic [31:0] rd;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [4:0]  out_addr;
   logic        busy;
   logic        done;
   logic [1:0]  dbg_state;

   modport master (
      output start, abort, rd, out_ready,
      input  ra, out_valid, out_data, out_addr, busy, done, dbg_state
   );

   modport slave (
      input  start, abort, rd, out_ready,
      output ra, out_valid, out_data, out_addr, busy, done, dbg_state
   );
endinterface

// File: rtl/regfile_dump.sv
// -----------------------------------------------------------------------------
// regfile_dump
// Debug readout engine for the CPU register file. On start it walks register
// indices FIRST_REG..LAST_REG through one regfile read port and streams each
// (index, value) pair out over a valid/ready handshake.
//
// Parameters:
//   FIRST_REG  first register index dumped (0..31)
//   LAST_REG   last register index dumped (FIRST_REG..31)
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high reset
//   bus    regfile_dump_if.slave: start/abort control, regfile read port
//          (ra/rd), output stream (out_valid/out_ready/out_data/out_addr),
//          status (busy/done) and FSM state for debug (dbg_state)
//
// Each word costs two cycles: READ presents ra and captures rd, SEND holds
// the word until accepted. All outputs are registered except ra and busy,
// which decode from state/idx.
// -----------------------------------------------------------------------------
module regfile_dump #(
   parameter int FIRST_REG = 0,
   parameter int LAST_REG  = 31
) (
   input  logic          clk,
   input  logic          reset,
   regfile_dump_if.slave bus
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_READ = 2'd1;
   localparam logic [1:0] ST_SEND = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
   localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

   logic [1:0]  state_q, state_d;
   logic [4:0]  idx_q, idx_d;
   logic        out_valid_q, out_valid_d;
   logic [31:0] out_data_q, out_data_d;
   logic [4:0]  out_addr_q, out_addr_d;
   logic        done_q, done_d;

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_addr_d  = out_addr_q;
      done_d      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // abort is meaningless here, so start always wins
            if (bus.start) begin
               idx_d   = FIRST_IDX;
               state_d = ST_READ;
            end
         end
         ST_READ: begin
            if (bus.abort) begin
               out_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end else begin
               // rd is sampled before any same-edge regfile write lands
               out_data_d  = bus.rd;
               out_addr_d  = idx_q;
               out_valid_d = 1'b1;
               state_d     = ST_SEND;
            end
         end
         ST_SEND: begin
            // abort beats a transfer offered on the same edge
            if (bus.abort) begin
               out_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end else if (bus.out_ready) begin
               out_valid_d = 1'b0;
               if (idx_q == LAST_IDX) begin
                  // stop here so idx never advances past LAST_REG
                  done_d  = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  idx_d   = idx_q + 5'd1;
                  state_d = ST_READ;
               end
            end
         end
         default: begin
            // ST_DONE: done is high for exactly this cycle
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         idx_q       <= 5'd0;
         out_valid_q <= 1'b0;
         out_data_q  <= 32'd0;
         out_addr_q  <= 5'd0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_addr_q  <= out_addr_d;
         done_q      <= done_d;
      end
   end

   assign bus.ra        = (state_q == ST_READ) ? idx_q : 5'd0;
   assign bus.busy      = (state_q != ST_IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_addr  = out_addr_q;
   assign bus.done      = done_q;
   assign bus.dbg_state = state_q;

endmodule
